// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W           = 4;
    localparam int unsigned RD_LATENCY_DFLT = 1;
    localparam int unsigned TAG_DEPTH       = RD_LATENCY_DFLT + 1;

    typedef struct packed {
        logic valid;
        logic is_fetch;
    } rsp_tag_t;

    function automatic int unsigned tag_depth(input int unsigned rd_latency);
        return rd_latency + 1;
    endfunction

endpackage

// File: rtl/mem_rsp_tracker.sv
// Tracks in-flight SRAM reads so each response returns to its requester;
// fetch tags are killed on a pipeline redirect.
module mem_rsp_tracker
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic flush,
    input  logic push_valid,
    input  logic push_fetch,
    output logic ifetch_rvalid,
    output logic data_rvalid
);

    // The last of the tag_depth() stages is held pre-decoded as the two rvalid flops.
    localparam int unsigned NPIPE = tag_depth(RD_LATENCY) - 1;

    rsp_tag_t tag_q    [NPIPE];
    rsp_tag_t tag_kill [NPIPE];

    always_comb begin
        for (int unsigned i = 0; i < NPIPE; i++) begin
            tag_kill[i] = tag_q[i];
            if (flush && tag_q[i].is_fetch) begin
                tag_kill[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NPIPE; i++) begin
                tag_q[i] <= '0;
            end
            ifetch_rvalid <= 1'b0;
            data_rvalid   <= 1'b0;
        end else begin
            tag_q[0].valid    <= push_valid;
            tag_q[0].is_fetch <= push_fetch;
            for (int unsigned i = 1; i < NPIPE; i++) begin
                tag_q[i] <= tag_kill[i-1];
            end
            ifetch_rvalid <= tag_kill[NPIPE-1].valid &  tag_kill[NPIPE-1].is_fetch;
            data_rvalid   <= tag_kill[NPIPE-1].valid & ~tag_kill[NPIPE-1].is_fetch;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and the load/store unit,
// with bounded fetch starvation and flush-aware response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_stall,
    output logic        ifetch_rvalid,
    output logic [31:0] ifetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_pend;
    logic             starved;
    logic             data_grant;
    logic             fetch_grant;

    // Data has priority unless fetch has waited through STARVE_LIMIT data grants.
    always_comb begin
        fetch_pend  = ifetch_req & ~flush;
        starved     = fetch_pend & (starve_cnt == STARVE_MAX);
        data_grant  = data_req & ~starved;
        fetch_grant = fetch_pend & ~data_grant;
    end

    assign ifetch_stall = fetch_pend & ~fetch_grant;
    assign data_gnt     = data_grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (fetch_grant || !fetch_pend) begin
            starve_cnt <= '0;
        end else if (data_grant && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Issue registers: address and write data hold when nothing is granted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= data_grant | fetch_grant;
            mem_we <= data_grant & data_we;
            mem_be <= data_grant ? data_be : 4'b0000;
            if (data_grant) begin
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
            end else if (fetch_grant) begin
                mem_addr  <= ifetch_addr;
                mem_wdata <= '0;
            end
        end
    end

    assign ifetch_rdata = mem_rdata;
    assign data_rdata   = mem_rdata;

    mem_rsp_tracker #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rsp_tracker (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .push_valid    (fetch_grant | (data_grant & ~data_we)),
        .push_fetch    (fetch_grant),
        .ifetch_rvalid (ifetch_rvalid),
        .data_rvalid   (data_rvalid)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at read latency 1, one at latency 2,
// sharing stimulus, each backed by its own SRAM read pipeline.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush, ifetch_req, data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] ifetch_addr, data_addr, data_wdata;

    logic        stall1, irv1, drv1, gnt1, en1, we1;
    logic [3:0]  be1;
    logic [31:0] ird1, drd1, addr1, wd1, rd1;
    logic        stall2, irv2, drv2, gnt2, en2, we2;
    logic [3:0]  be2;
    logic [31:0] ird2, drd2, addr2, wd2, rd2, rd2a;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // SRAM read data pipelines: valid RD_LATENCY cycles after the mem_en cycle.
    always @(posedge clk) begin
        rd1  <= (en1 && !we1) ? mem_f(addr1) : 32'hDEAD_BEEF;
        rd2a <= (en2 && !we2) ? mem_f(addr2) : 32'hDEAD_BEEF;
        rd2  <= rd2a;
    end

    mem_port_arbiter #(.RD_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_stall(stall1),
        .ifetch_rvalid(irv1), .ifetch_rdata(ird1),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(gnt1), .data_rvalid(drv1), .data_rdata(drd1),
        .mem_en(en1), .mem_we(we1), .mem_be(be1), .mem_addr(addr1), .mem_wdata(wd1),
        .mem_rdata(rd1)
    );

    mem_port_arbiter #(.RD_LATENCY(2), .STARVE_LIMIT(4)) u_dut2 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_stall(stall2),
        .ifetch_rvalid(irv2), .ifetch_rdata(ird2),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(gnt2), .data_rvalid(drv2), .data_rdata(drd2),
        .mem_en(en2), .mem_we(we2), .mem_be(be2), .mem_addr(addr2), .mem_wdata(wd2),
        .mem_rdata(rd2)
    );

    task automatic idle();
        flush = 1'b0; ifetch_req = 1'b0; ifetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        next_cycle();
        n_checks++; if (en1 !== 1'b0) begin n_fail++; $display("FAIL rst_en1: got %b exp 0", en1); end
        n_checks++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL rst_we1: got %b exp 0", we1); end
        n_checks++; if (be1 !== 4'h0) begin n_fail++; $display("FAIL rst_be1: got %h exp 0", be1); end
        n_checks++; if (addr1 !== 32'h0) begin n_fail++; $display("FAIL rst_addr1: got %h exp 0", addr1); end
        n_checks++; if (wd1 !== 32'h0) begin n_fail++; $display("FAIL rst_wdata1: got %h exp 0", wd1); end
        n_checks++; if (irv1 !== 1'b0) begin n_fail++; $display("FAIL rst_irv1: got %b exp 0", irv1); end
        n_checks++; if (drv1 !== 1'b0) begin n_fail++; $display("FAIL rst_drv1: got %b exp 0", drv1); end
        n_checks++; if (en2 !== 1'b0) begin n_fail++; $display("FAIL rst_en2: got %b exp 0", en2); end
        n_checks++; if (irv2 !== 1'b0) begin n_fail++; $display("FAIL rst_irv2: got %b exp 0", irv2); end
        n_checks++; if (drv2 !== 1'b0) begin n_fail++; $display("FAIL rst_drv2: got %b exp 0", drv2); end
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        n_checks++; if (en1 !== 1'b0) begin n_fail++; $display("FAIL post_rst_en1: got %b exp 0", en1); end
        n_checks++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL post_rst_stall1: got %b exp 0", stall1); end
        n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL post_rst_gnt1: got %b exp 0", gnt1); end
    endtask

    task automatic test_fetch_only();
        logic exp_en, exp_rv1, exp_rv2;
        for (int c = 0; c < 7; c++) begin
            idle();
            ifetch_req  = (c < 3);
            ifetch_addr = 32'(4 * c);
            @(negedge clk);
            exp_en  = (c >= 1 && c <= 3);
            exp_rv1 = (c >= 2 && c <= 4);
            exp_rv2 = (c >= 3 && c <= 5);
            n_checks++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL fo_stall1 c=%0d: got %b exp 0", c, stall1); end
            n_checks++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL fo_stall2 c=%0d: got %b exp 0", c, stall2); end
            n_checks++; if (en1 !== exp_en) begin n_fail++; $display("FAIL fo_en1 c=%0d: got %b exp %b", c, en1, exp_en); end
            if (exp_en) begin
                n_checks++; if (addr1 !== 32'(4 * (c - 1))) begin n_fail++; $display("FAIL fo_addr1 c=%0d: got %h exp %h", c, addr1, 32'(4 * (c - 1))); end
                n_checks++; if ({we1, be1, wd1} !== 37'h0) begin n_fail++; $display("FAIL fo_wctl1 c=%0d: got we=%b be=%h wd=%h exp zeros", c, we1, be1, wd1); end
            end
            n_checks++; if (irv1 !== exp_rv1) begin n_fail++; $display("FAIL fo_irv1 c=%0d: got %b exp %b", c, irv1, exp_rv1); end
            if (exp_rv1) begin
                n_checks++; if (ird1 !== mem_f(32'(4 * (c - 2)))) begin n_fail++; $display("FAIL fo_ird1 c=%0d: got %h exp %h", c, ird1, mem_f(32'(4 * (c - 2)))); end
            end
            n_checks++; if (irv2 !== exp_rv2) begin n_fail++; $display("FAIL fo_irv2 c=%0d: got %b exp %b", c, irv2, exp_rv2); end
            if (exp_rv2) begin
                n_checks++; if (ird2 !== mem_f(32'(4 * (c - 3)))) begin n_fail++; $display("FAIL fo_ird2 c=%0d: got %h exp %h", c, ird2, mem_f(32'(4 * (c - 3)))); end
            end
            n_checks++; if (drv1 !== 1'b0) begin n_fail++; $display("FAIL fo_drv1 c=%0d: got %b exp 0", c, drv1); end
            next_cycle();
        end
        drain(4);
    endtask

    task automatic test_load_vs_fetch();
        int n_drv = 0;
        int n_irv = 0;
        for (int c = 0; c < 6; c++) begin
            idle();
            data_req = (c == 0); data_be = 4'hF; data_addr = 32'h100;
            ifetch_req = (c <= 1); ifetch_addr = 32'h10;
            @(negedge clk);
            if (c == 0) begin
                n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL lf_gnt c0: got %b exp 1", gnt1); end
                n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL lf_stall c0: got %b exp 1", stall1); end
            end
            if (c == 1) begin
                n_checks++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL lf_stall c1: got %b exp 0", stall1); end
                n_checks++; if ({en1, we1, be1, addr1} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin n_fail++; $display("FAIL lf_issue_load: got en=%b we=%b be=%h addr=%h exp 1 0 f 100", en1, we1, be1, addr1); end
            end
            if (c == 2) begin
                n_checks++; if ({en1, be1, addr1} !== {1'b1, 4'h0, 32'h10}) begin n_fail++; $display("FAIL lf_issue_fetch: got en=%b be=%h addr=%h exp 1 0 10", en1, be1, addr1); end
                n_checks++; if ({drv1, irv1} !== 2'b10) begin n_fail++; $display("FAIL lf_rv_c2: got drv=%b irv=%b exp 1 0", drv1, irv1); end
                n_checks++; if (drd1 !== mem_f(32'h100)) begin n_fail++; $display("FAIL lf_drd: got %h exp %h", drd1, mem_f(32'h100)); end
            end
            if (c == 3) begin
                n_checks++; if ({drv1, irv1} !== 2'b01) begin n_fail++; $display("FAIL lf_rv_c3: got drv=%b irv=%b exp 0 1", drv1, irv1); end
                n_checks++; if (ird1 !== mem_f(32'h10)) begin n_fail++; $display("FAIL lf_ird: got %h exp %h", ird1, mem_f(32'h10)); end
            end
            if (drv1) n_drv++;
            if (irv1) n_irv++;
            next_cycle();
        end
        n_checks++; if (n_drv != 1) begin n_fail++; $display("FAIL lf_drv_count: got %0d exp 1", n_drv); end
        n_checks++; if (n_irv != 1) begin n_fail++; $display("FAIL lf_irv_count: got %0d exp 1", n_irv); end
        drain(4);
    endtask

    task automatic test_starvation();
        logic exp_g;
        int n_dg = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            data_req = (c < 10); data_be = 4'hF; data_addr = 32'h300 + 32'(4 * c);
            ifetch_req = 1'b1; ifetch_addr = 32'h80;
            @(negedge clk);
            exp_g = (c < 10) && ((c % 5) != 4);
            n_checks++; if (gnt1 !== exp_g) begin n_fail++; $display("FAIL st_gnt1 c=%0d: got %b exp %b", c, gnt1, exp_g); end
            n_checks++; if (stall1 !== exp_g) begin n_fail++; $display("FAIL st_stall1 c=%0d: got %b exp %b", c, stall1, exp_g); end
            n_checks++; if (gnt2 !== exp_g) begin n_fail++; $display("FAIL st_gnt2 c=%0d: got %b exp %b", c, gnt2, exp_g); end
            if (gnt1) n_dg++;
            next_cycle();
        end
        n_checks++; if (n_dg != 8) begin n_fail++; $display("FAIL st_data_grants: got %0d exp 8", n_dg); end
        drain(5);
    endtask

    task automatic test_flush();
        for (int c = 0; c < 8; c++) begin
            idle();
            ifetch_req  = (c <= 2);
            ifetch_addr = (c == 0) ? 32'h20 : (c == 1) ? 32'h24 : 32'h28;
            flush       = (c == 2);
            data_req    = (c == 2); data_be = 4'hF; data_addr = 32'h400;
            @(negedge clk);
            if (c == 2) begin
                n_checks++; if ({stall1, gnt1, stall2, gnt2} !== 4'b0101) begin n_fail++; $display("FAIL fl_arb: got stall1=%b gnt1=%b stall2=%b gnt2=%b exp 0 1 0 1", stall1, gnt1, stall2, gnt2); end
            end
            if (c == 3) begin
                n_checks++; if ({en2, addr2} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL fl_issue2: got en=%b addr=%h exp 1 400", en2, addr2); end
            end
            n_checks++; if (irv2 !== 1'b0) begin n_fail++; $display("FAIL fl_irv2 c=%0d: got %b exp 0", c, irv2); end
            n_checks++; if (drv2 !== (c == 5)) begin n_fail++; $display("FAIL fl_drv2 c=%0d: got %b exp %b", c, drv2, (c == 5)); end
            if (c == 5) begin
                n_checks++; if (drd2 !== mem_f(32'h400)) begin n_fail++; $display("FAIL fl_drd2: got %h exp %h", drd2, mem_f(32'h400)); end
            end
            n_checks++; if (irv1 !== (c == 2)) begin n_fail++; $display("FAIL fl_irv1 c=%0d: got %b exp %b", c, irv1, (c == 2)); end
            if (c == 2) begin
                n_checks++; if (ird1 !== mem_f(32'h20)) begin n_fail++; $display("FAIL fl_ird1: got %h exp %h", ird1, mem_f(32'h20)); end
            end
            n_checks++; if (drv1 !== (c == 4)) begin n_fail++; $display("FAIL fl_drv1 c=%0d: got %b exp %b", c, drv1, (c == 4)); end
            next_cycle();
        end
        drain(2);
    endtask

    task automatic test_store();
        for (int c = 0; c < 6; c++) begin
            idle();
            data_req = (c == 0); data_we = 1'b1; data_be = 4'b0011;
            data_addr = 32'h200; data_wdata = 32'h1234_5678;
            @(negedge clk);
            if (c == 0) begin
                n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL sw_gnt: got %b exp 1", gnt1); end
            end
            if (c == 1) begin
                n_checks++; if ({en1, we1, be1} !== {1'b1, 1'b1, 4'b0011}) begin n_fail++; $display("FAIL sw_issue_ctl: got en=%b we=%b be=%b exp 1 1 0011", en1, we1, be1); end
                n_checks++; if ({addr1, wd1} !== {32'h200, 32'h1234_5678}) begin n_fail++; $display("FAIL sw_issue_data: got addr=%h wd=%h exp 200 12345678", addr1, wd1); end
            end
            if (c == 2) begin
                n_checks++; if ({en1, we1, be1} !== 6'b0) begin n_fail++; $display("FAIL sw_idle_ctl: got en=%b we=%b be=%b exp 0 0 0000", en1, we1, be1); end
                n_checks++; if ({addr1, wd1} !== {32'h200, 32'h1234_5678}) begin n_fail++; $display("FAIL sw_hold: got addr=%h wd=%h exp 200 12345678", addr1, wd1); end
            end
            n_checks++; if ({irv1, drv1, irv2, drv2} !== 4'b0) begin n_fail++; $display("FAIL sw_no_rsp c=%0d: got %b%b%b%b exp 0000", c, irv1, drv1, irv2, drv2); end
            next_cycle();
        end
        drain(2);
    endtask

    task automatic test_reset_inflight();
        idle(); ifetch_req = 1'b1; ifetch_addr = 32'h40;
        next_cycle();
        idle(); data_req = 1'b1; data_be = 4'hF; data_addr = 32'h500;
        next_cycle();
        idle();
        n_checks++; if ({en1, irv1} !== 2'b11) begin n_fail++; $display("FAIL ri_inflight: got en=%b irv=%b exp 1 1", en1, irv1); end
        resetn = 1'b0;
        #1;
        n_checks++; if ({en1, we1, be1, addr1, wd1, irv1, drv1} !== 72'h0) begin n_fail++; $display("FAIL ri_zero1: got en=%b we=%b be=%h addr=%h wd=%h irv=%b drv=%b exp zeros", en1, we1, be1, addr1, wd1, irv1, drv1); end
        n_checks++; if ({en2, we2, be2, addr2, wd2, irv2, drv2} !== 72'h0) begin n_fail++; $display("FAIL ri_zero2: got en=%b we=%b be=%h addr=%h wd=%h irv=%b drv=%b exp zeros", en2, we2, be2, addr2, wd2, irv2, drv2); end
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if ({irv1, drv1, irv2, drv2} !== 4'b0) begin n_fail++; $display("FAIL ri_stale c=%0d: got %b%b%b%b exp 0000", c, irv1, drv1, irv2, drv2); end
            next_cycle();
        end
        for (int c = 0; c < 5; c++) begin
            idle(); ifetch_req = (c == 0); ifetch_addr = 32'h60;
            @(negedge clk);
            n_checks++; if (irv1 !== (c == 2)) begin n_fail++; $display("FAIL ri_irv1 c=%0d: got %b exp %b", c, irv1, (c == 2)); end
            n_checks++; if (irv2 !== (c == 3)) begin n_fail++; $display("FAIL ri_irv2 c=%0d: got %b exp %b", c, irv2, (c == 3)); end
            if (c == 2) begin
                n_checks++; if (ird1 !== mem_f(32'h60)) begin n_fail++; $display("FAIL ri_ird1: got %h exp %h", ird1, mem_f(32'h60)); end
            end
            next_cycle();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch_only();
        test_load_vs_fetch();
        test_starvation();
        test_flush();
        test_store();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
